weight_pingpong_buffer: RTL and testbench
=========================================

Name: weight_pingpong_buffer

Overview:
- Double-buffered weight staging stage between the weight ROM (rom_memory2) and the systolic array f_weight_i inputs.
- Replaces the single weight register bank.
- Prefetches the weight word for round r+1 into a shadow bank while round r weights are active.
- The controller swaps banks on a one-cycle pulse, hiding ROM read latency between weight rounds.

Parameters:
- N_ROWS_ARRAY, 9, number of array rows; one weight per row per word.
- F_WIDTH, 8, signed weight width.
- SIG_ADDRS_WIDTH, 10, weight ROM address width.
- COUNTER_ROUND_WIDTH, 3, width of the round-count input and counters.

Ports:
- clk_i  in  1  clock.
- rd_weight_rst  in  1  reset, asynchronous, active-high.
- fetch_start_i  in  1  pulse; starts a new weight sequence (honoured only in IDLE).
- base_addr_i  in  SIG_ADDRS_WIDTH  ROM address of round 0 weights; sampled on an accepted fetch_start_i.
- n_round_weight_i  in  COUNTER_ROUND_WIDTH  number of rounds; sampled on an accepted fetch_start_i.
- mem_addr_o  out  SIG_ADDRS_WIDTH  ROM read address.
- mem_rd_ld_o  out  1  ROM read strobe; data is valid on mem_data_i the following cycle.
- mem_data_i  in  N_ROWS_ARRAY*F_WIDTH  ROM word; row i occupies bits [(i+1)*F_WIDTH-1 : i*F_WIDTH].
- swap_i  in  1  pulse; promote shadow bank to active.
- f_weight_o  out  F_WIDTH x [0:N_ROWS_ARRAY-1]  signed active weights to the array.
- shadow_valid_o  out  1  shadow bank holds an unconsumed word.
- busy_o  out  1  sequence in progress (state != IDLE).
- last_round_o  out  1  active bank holds the final round of the sequence.
- done_o  out  1  one-cycle pulse when the final round is swapped in.

Behaviour:
- Reset (asynchronous, rd_weight_rst=1): all f_weight_o=0; shadow bank=0; shadow_valid_o=0; mem_rd_ld_o=0; mem_addr_o=0; busy_o=0; last_round_o=0; done_o=0; counters=0; state IDLE. Mid-operation reset aborts immediately with no pending fetch completed.
- States:
  - IDLE: on fetch_start_i with n_round_weight_i!=0, latch base and n; fetch_idx=0, swap_idx=0; go to FETCH. With n_round_weight_i==0, stay IDLE and pulse done_o next cycle.
  - FETCH (1 cycle): mem_rd_ld_o=1, mem_addr_o=base+fetch_idx (mod 2^SIG_ADDRS_WIDTH); go to CAPTURE.
  - CAPTURE (1 cycle): shadow<=mem_data_i; shadow_valid_o=1 from the next cycle; fetch_idx++; go to WAIT.
  - WAIT: hold until swap_i.
- Swap (swap_i=1 and shadow_valid_o=1), effects next edge:
  - active<=shadow, shadow_valid_o<=0, swap_idx++.
  - last_round_o<=(swap_idx+1==n).
  - If fetch_idx<n, go to FETCH; else go to IDLE and pulse done_o.
- swap_i while shadow_valid_o=0 (FETCH, CAPTURE, IDLE): ignored; active bank unchanged.
- fetch_start_i while busy_o=1: ignored.
- mem_rd_ld_o is 0 in every state except FETCH; mem_addr_o holds its last value otherwise.
- Latency: fetch_start at cycle 0 → FETCH at cycle 1 → shadow_valid_o=1 at cycle 3.
- Swap at cycle k:
  - f_weight_o updated at k+1.
  - Next shadow_valid_o at k+3 (if rounds remain).
  - Minimum round period is 3 cycles.
- After done_o: active weights and last_round_o persist until the next sequence's first swap or reset. last_round_o clears on the first swap of a new sequence with n>1.
- Address wrap: base+idx wraps modulo 2^SIG_ADDRS_WIDTH, with no error.

Optional Feature:
- Macro WEIGHT_BUF_STALL_CNT_EN.
- Defined: adds output stall_cnt_o (16 bit).
  - Increments each cycle busy_o=1 and state is FETCH or CAPTURE while swap_i=1 (controller stalled on prefetch).
  - Saturates at 16'hFFFF; cleared by reset and by an accepted fetch_start_i.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then idle: rd_weight_rst pulse mid-cycle → all f_weight_o=0, shadow_valid_o=0, busy_o=0 asynchronously, before the next clock edge.
- Basic sequence: base=5, n=3, ROM words W5..W7, swaps on each shadow_valid_o →
  - mem_addr_o 5,6,7 with a single-cycle mem_rd_ld_o each;
  - f_weight_o = W5, W6, W7;
  - last_round_o=1 only with W7;
  - done_o pulses once, on the cycle after the third swap.
- Early swap: swap_i asserted in the FETCH cycle → ignored, f_weight_o unchanged; a later swap with shadow_valid_o=1 is accepted. With WEIGHT_BUF_STALL_CNT_EN defined, stall_cnt_o=1.
- Wrap and n=0:
  - base=1022, n=4 → addresses 1022, 1023, 0, 1.
  - fetch_start with n=0 → no mem_rd_ld_o, done_o pulse, busy_o stays 0.
- Reset mid-sequence: assert rd_weight_rst in CAPTURE of round 1 → shadow_valid_o=0, state IDLE. A new fetch_start with base=0, n=1 then completes normally, with f_weight_o=W0.
- Ignored restart: fetch_start_i with base=9 while busy → mem_addr_o continues the original sequence, with no restart.

Source files
------------

// File: rtl/weight_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : weight_pingpong_buffer
// Purpose  : Double-buffered weight staging between the weight ROM and the
//            systolic array; prefetches round r+1 while round r is active.
// Options  : WEIGHT_BUF_STALL_CNT_EN adds the 16-bit stall_cnt_o counter.
// Revision : 1.0 - initial release
// ============================================================================
module weight_pingpong_buffer #(
  parameter int N_ROWS_ARRAY        = 9,
  parameter int F_WIDTH             = 8,
  parameter int SIG_ADDRS_WIDTH     = 10,
  parameter int COUNTER_ROUND_WIDTH = 3
) (
  input  logic                              clk_i,
  input  logic                              rd_weight_rst,
  input  logic                              fetch_start_i,
  input  logic [SIG_ADDRS_WIDTH-1:0]        base_addr_i,
  input  logic [COUNTER_ROUND_WIDTH-1:0]    n_round_weight_i,
  output logic [SIG_ADDRS_WIDTH-1:0]        mem_addr_o,
  output logic                              mem_rd_ld_o,
  input  logic [N_ROWS_ARRAY*F_WIDTH-1:0]   mem_data_i,
  input  logic                              swap_i,
  output logic signed [F_WIDTH-1:0]         f_weight_o [0:N_ROWS_ARRAY-1],
  output logic                              shadow_valid_o,
  output logic                              busy_o,
  output logic                              last_round_o,
  output logic                              done_o
`ifdef WEIGHT_BUF_STALL_CNT_EN
  ,
  output logic [15:0]                       stall_cnt_o
`endif
);

  localparam int CRW1 = COUNTER_ROUND_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_CAPTURE = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

  state_t                           state_q;
  logic [SIG_ADDRS_WIDTH-1:0]       base_q;
  logic [COUNTER_ROUND_WIDTH-1:0]   n_q;
  logic [COUNTER_ROUND_WIDTH-1:0]   fetch_idx_q;
  logic [COUNTER_ROUND_WIDTH-1:0]   swap_idx_q;
  logic [SIG_ADDRS_WIDTH-1:0]       mem_addr_q;
  logic                             mem_rd_ld_q;
  logic                             shadow_valid_q;
  logic                             last_round_q;
  logic                             done_q;
  logic signed [F_WIDTH-1:0]        shadow_q [N_ROWS_ARRAY];
  logic signed [F_WIDTH-1:0]        active_q [N_ROWS_ARRAY];

  logic [SIG_ADDRS_WIDTH-1:0]       addr_d;
  logic [CRW1-1:0]                  swap_idx_d;
  logic                             swap_ok;

  // Address wraps naturally at the ROM address width.
  assign addr_d     = base_q + SIG_ADDRS_WIDTH'(fetch_idx_q);
  assign swap_idx_d = {1'b0, swap_idx_q} + CRW1'(1);
  assign swap_ok    = swap_i && shadow_valid_q;

  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      n_q            <= '0;
      fetch_idx_q    <= '0;
      swap_idx_q     <= '0;
      mem_addr_q     <= '0;
      mem_rd_ld_q    <= 1'b0;
      shadow_valid_q <= 1'b0;
      last_round_q   <= 1'b0;
      done_q         <= 1'b0;
      for (int i = 0; i < N_ROWS_ARRAY; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      done_q      <= 1'b0;
      mem_rd_ld_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (fetch_start_i) begin
            if (n_round_weight_i != '0) begin
              base_q      <= base_addr_i;
              n_q         <= n_round_weight_i;
              fetch_idx_q <= '0;
              swap_idx_q  <= '0;
              mem_addr_q  <= base_addr_i;
              mem_rd_ld_q <= 1'b1;
              state_q     <= S_FETCH;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_FETCH: state_q <= S_CAPTURE;
        S_CAPTURE: begin
          for (int i = 0; i < N_ROWS_ARRAY; i++)
            shadow_q[i] <= mem_data_i[i*F_WIDTH +: F_WIDTH];
          shadow_valid_q <= 1'b1;
          fetch_idx_q    <= fetch_idx_q + COUNTER_ROUND_WIDTH'(1);
          state_q        <= S_WAIT;
        end
        S_WAIT: begin
          if (swap_ok) begin
            active_q       <= shadow_q;
            shadow_valid_q <= 1'b0;
            swap_idx_q     <= swap_idx_d[COUNTER_ROUND_WIDTH-1:0];
            last_round_q   <= (swap_idx_d == {1'b0, n_q});
            if (fetch_idx_q < n_q) begin
              mem_addr_q  <= addr_d;
              mem_rd_ld_q <= 1'b1;
              state_q     <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr_o     = mem_addr_q;
  assign mem_rd_ld_o    = mem_rd_ld_q;
  assign shadow_valid_o = shadow_valid_q;
  assign busy_o         = (state_q != S_IDLE);
  assign last_round_o   = last_round_q;
  assign done_o         = done_q;

  for (genvar g = 0; g < N_ROWS_ARRAY; g++) begin : g_weight_out
    assign f_weight_o[g] = active_q[g];
  end

`ifdef WEIGHT_BUF_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Counts cycles where the controller wants a swap but the prefetch is still in flight.
  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) begin
      stall_cnt_q <= '0;
    end else if (state_q == S_IDLE && fetch_start_i) begin
      stall_cnt_q <= '0;
    end else if (swap_i && (state_q == S_FETCH || state_q == S_CAPTURE)
                 && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_pingpong_buffer
// Purpose  : Directed self-checking bench for weight_pingpong_buffer with a
//            ROM model and address/weight scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_pingpong_buffer;

  localparam int NR = 9;
  localparam int FW = 8;
  localparam int AW = 10;
  localparam int CW = 3;
  localparam int WW = NR * FW;

  logic                  clk_i = 1'b0;
  logic                  rd_weight_rst = 1'b1;
  logic                  fetch_start_i = 1'b0;
  logic [AW-1:0]         base_addr_i = '0;
  logic [CW-1:0]         n_round_weight_i = '0;
  logic [AW-1:0]         mem_addr_o;
  logic                  mem_rd_ld_o;
  logic [WW-1:0]         mem_data_i = '0;
  logic                  swap_i = 1'b0;
  logic signed [FW-1:0]  f_weight_o [0:NR-1];
  logic                  shadow_valid_o;
  logic                  busy_o;
  logic                  last_round_o;
  logic                  done_o;
`ifdef WEIGHT_BUF_STALL_CNT_EN
  logic [15:0]           stall_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] exp_addr_q [$];
  logic [WW-1:0] exp_w_q    [$];

  weight_pingpong_buffer #(
    .N_ROWS_ARRAY(NR), .F_WIDTH(FW), .SIG_ADDRS_WIDTH(AW), .COUNTER_ROUND_WIDTH(CW)
  ) dut (
    .clk_i            (clk_i),
    .rd_weight_rst    (rd_weight_rst),
    .fetch_start_i    (fetch_start_i),
    .base_addr_i      (base_addr_i),
    .n_round_weight_i (n_round_weight_i),
    .mem_addr_o       (mem_addr_o),
    .mem_rd_ld_o      (mem_rd_ld_o),
    .mem_data_i       (mem_data_i),
    .swap_i           (swap_i),
    .f_weight_o       (f_weight_o),
    .shadow_valid_o   (shadow_valid_o),
    .busy_o           (busy_o),
    .last_round_o     (last_round_o),
    .done_o           (done_o)
`ifdef WEIGHT_BUF_STALL_CNT_EN
    ,
    .stall_cnt_o      (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [WW-1:0] rom_word(input logic [AW-1:0] a);
    logic [WW-1:0] w;
    for (int i = 0; i < NR; i++) w[i*FW +: FW] = 8'(int'(a) * 7 + i * 13 + 3);
    return w;
  endfunction

  // ROM with one-cycle read latency
  always @(posedge clk_i) if (mem_rd_ld_o) mem_data_i <= rom_word(mem_addr_o);

  function automatic logic [WW-1:0] pack_fw();
    logic [WW-1:0] p;
    for (int i = 0; i < NR; i++) p[i*FW +: FW] = f_weight_o[i];
    return p;
  endfunction

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge and score any ROM read.
  task automatic tick();
    @(posedge clk_i); #1;
    if (mem_rd_ld_o) begin
      if (exp_addr_q.size() == 0) check("rd_unexpected", WW'(mem_rd_ld_o), WW'(0));
      else check("mem_addr", WW'(mem_addr_o), WW'(exp_addr_q.pop_front()));
    end
  endtask

  // mode 0: normal, 1: early swap in FETCH of round 0, 2: restart attempt while busy
  task automatic run_seq(input logic [AW-1:0] base, input logic [CW-1:0] n, input int mode);
    logic [WW-1:0] prev;
    int t;
    int exp_t;
    for (int i = 0; i < int'(n); i++) begin
      exp_addr_q.push_back(base + AW'(i));
      exp_w_q.push_back(rom_word(base + AW'(i)));
    end
    fetch_start_i = 1'b1; base_addr_i = base; n_round_weight_i = n;
    tick();
    fetch_start_i = 1'b0;
    check("busy_start", WW'(busy_o), WW'(1));
    if (mode == 1) begin
      prev = pack_fw();
      swap_i = 1'b1;
      tick();
      swap_i = 1'b0;
      check("early_swap_ignored", pack_fw(), prev);
    end else if (mode == 2) begin
      fetch_start_i = 1'b1; base_addr_i = 10'd9; n_round_weight_i = 3'd5;
      tick();
      fetch_start_i = 1'b0;
    end
    for (int r = 0; r < int'(n); r++) begin
      exp_t = (r == 0 && mode != 0) ? 1 : 2;
      t = 0;
      while (!shadow_valid_o && t < 10) begin tick(); t++; end
      check("shadow_latency", WW'(t), WW'(exp_t));
      swap_i = 1'b1;
      tick();
      swap_i = 1'b0;
      check("f_weight", pack_fw(), exp_w_q.pop_front());
      check("last_round", WW'(last_round_o), WW'(r == int'(n) - 1));
      check("done_pulse", WW'(done_o), WW'(r == int'(n) - 1));
    end
    check("busy_end", WW'(busy_o), WW'(0));
    tick();
    check("done_single", WW'(done_o), WW'(0));
  endtask

  initial begin
    #2;
    check("rst_fw", pack_fw(), '0);
    check("rst_sv", WW'(shadow_valid_o), WW'(0));
    check("rst_rd", WW'(mem_rd_ld_o), WW'(0));
    check("rst_addr", WW'(mem_addr_o), WW'(0));
    check("rst_busy_last_done", WW'({busy_o, last_round_o, done_o}), WW'(0));
    tick();
    rd_weight_rst = 1'b0;
    tick();

    // Basic sequence, then persistence after done
    run_seq(10'd5, 3'd3, 0);
    check("persist_last", WW'(last_round_o), WW'(1));
    check("persist_fw", pack_fw(), rom_word(10'd7));

    // Asynchronous reset mid-cycle
    #3 rd_weight_rst = 1'b1;
    #1;
    check("async_fw", pack_fw(), '0);
    check("async_sv_busy_last", WW'({shadow_valid_o, busy_o, last_round_o}), WW'(0));
    #1 rd_weight_rst = 1'b0;
    tick();

    // Early swap during FETCH
    run_seq(10'd30, 3'd2, 1);
`ifdef WEIGHT_BUF_STALL_CNT_EN
    check("stall_cnt", WW'(stall_cnt_o), WW'(1));
`endif

    // Address wrap
    run_seq(10'd1022, 3'd4, 0);

    // n = 0: immediate done, no read
    fetch_start_i = 1'b1; base_addr_i = 10'd50; n_round_weight_i = 3'd0;
    tick();
    fetch_start_i = 1'b0;
    check("n0_done", WW'(done_o), WW'(1));
    check("n0_busy", WW'(busy_o), WW'(0));
    tick();
    check("n0_done_clear", WW'(done_o), WW'(0));

    // Reset during CAPTURE of round 1
    exp_addr_q.push_back(10'd2);
    exp_addr_q.push_back(10'd3);
    fetch_start_i = 1'b1; base_addr_i = 10'd2; n_round_weight_i = 3'd3;
    tick();
    fetch_start_i = 1'b0;
    tick(); tick();
    check("mid_sv_r0", WW'(shadow_valid_o), WW'(1));
    swap_i = 1'b1;
    tick();
    swap_i = 1'b0;
    check("mid_fw_r0", pack_fw(), rom_word(10'd2));
    tick();
    rd_weight_rst = 1'b1;
    #1;
    check("mid_rst_sv_busy", WW'({shadow_valid_o, busy_o}), WW'(0));
    check("mid_rst_fw", pack_fw(), '0);
    #1 rd_weight_rst = 1'b0;
    check("mid_no_pending_rd", WW'(exp_addr_q.size()), WW'(0));
    tick();
    run_seq(10'd0, 3'd1, 0);

    // Restart attempt while busy is ignored
    run_seq(10'd20, 3'd3, 2);
    check("queues_drained", WW'(exp_addr_q.size() + exp_w_q.size()), WW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
